// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Request / broadcast bundle between the functional units and
//               the common-data-bus arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32
) ();
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PREG_W-1:0] req_prd;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_tag;
    logic [NUM_REQ-1:0]        req_ready;

    // Mispredict and ROB age reference
    logic                      flush;
    logic [ROB_W-1:0]          flush_rob_tag;
    logic [ROB_W-1:0]          rob_head;

    // Registered broadcast
    logic                      cdb_valid;
    logic [PREG_W-1:0]         cdb_prd;
    logic [XLEN-1:0]           cdb_data;
    logic [ROB_W-1:0]          cdb_rob_tag;
    logic [SRC_W-1:0]          cdb_src;

    // Arbiter view
    modport slave (
        input  req_valid, req_prd, req_data, req_rob_tag,
        input  flush, flush_rob_tag, rob_head,
        output req_ready,
        output cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_src
    );

    // Functional-unit / pipeline view
    modport master (
        output req_valid, req_prd, req_data, req_rob_tag,
        output flush, flush_rob_tag, rob_head,
        input  req_ready,
        input  cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_src
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus arbiter. Round-robin grant with starvation
//               override, registered broadcast, mispredict squash of younger
//               results at the request inputs and at the output register.
// Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int PREG_W       = 7,
    parameter int ROB_W        = 4,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,   // synchronous, active-low
    cdb_arbiter_if.slave       bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

    // Age of a tag relative to the ROB head; wrap-around falls out of the modulo.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

    // State
    logic [SRC_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]  wait_cnt_d [NUM_REQ];
    logic              cdb_valid_q,   cdb_valid_d;
    logic [PREG_W-1:0] cdb_prd_q,     cdb_prd_d;
    logic [XLEN-1:0]   cdb_data_q,    cdb_data_d;
    logic [ROB_W-1:0]  cdb_rob_tag_q, cdb_rob_tag_d;
    logic [SRC_W-1:0]  cdb_src_q,     cdb_src_d;

    // Combinational arbitration signals
    logic [ROB_W-1:0]   branch_age;
    logic [NUM_REQ-1:0] younger;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] flush_ack;
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_found;
    logic [SRC_W-1:0]   win_idx;
    int                 rr_pos;
    logic [PREG_W-1:0]  sel_prd;
    logic [XLEN-1:0]    sel_data;
    logic [ROB_W-1:0]   sel_tag;
    logic               out_squash;

    // Classify each requester against the mispredicted branch and the starvation limit.
    always_comb begin
        branch_age = rob_age(bus.flush_rob_tag, bus.rob_head);
        younger    = '0;
        eligible   = '0;
        flush_ack  = '0;
        starved    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            younger[i]   = rob_age(bus.req_rob_tag[i*ROB_W +: ROB_W], bus.rob_head) > branch_age;
            eligible[i]  = bus.req_valid[i] && !(bus.flush && younger[i]);
            flush_ack[i] = bus.req_valid[i] && bus.flush && younger[i];
            starved[i]   = eligible[i] && (wait_cnt_q[i] >= LIMIT);
        end
    end

    // Pick the winner: lowest-index starved requester, else round-robin from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        win_idx     = '0;
        rr_pos      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && starved[i]) begin
                grant_found = 1'b1;
                win_idx     = SRC_W'(i);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_pos = int'(rr_ptr_q) + k;
            if (rr_pos >= NUM_REQ) begin
                rr_pos = rr_pos - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_found && eligible[j] && (j == rr_pos)) begin
                    grant_found = 1'b1;
                    win_idx     = SRC_W'(j);
                end
            end
        end
        grant_vec = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_vec[j] = grant_found && (win_idx == SRC_W'(j));
        end
    end

    // Mux the winner's payload onto the output-register inputs.
    always_comb begin
        sel_prd  = '0;
        sel_data = '0;
        sel_tag  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_vec[j]) begin
                sel_prd  = bus.req_prd[j*PREG_W +: PREG_W];
                sel_data = bus.req_data[j*XLEN +: XLEN];
                sel_tag  = bus.req_rob_tag[j*ROB_W +: ROB_W];
            end
        end
    end

    // Next-state: pointer advance, starvation counters, broadcast register.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end

        // A valid result acked by the flush neither counts as a loss nor clears the counter.
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!bus.req_valid[i] || grant_vec[i]) begin
                wait_cnt_d[i] = '0;
            end else if (eligible[i] && (wait_cnt_q[i] < LIMIT)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
            end
        end

        cdb_valid_d   = grant_found;
        cdb_prd_d     = grant_found ? sel_prd  : cdb_prd_q;
        cdb_data_d    = grant_found ? sel_data : cdb_data_q;
        cdb_rob_tag_d = grant_found ? sel_tag  : cdb_rob_tag_q;
        cdb_src_d     = grant_found ? win_idx  : cdb_src_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_prd_q     <= '0;
            cdb_data_q    <= '0;
            cdb_rob_tag_q <= '0;
            cdb_src_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_prd_q     <= cdb_prd_d;
            cdb_data_q    <= cdb_data_d;
            cdb_rob_tag_q <= cdb_rob_tag_d;
            cdb_src_q     <= cdb_src_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    // A registered wrong-path broadcast is killed in the flush cycle itself.
    assign out_squash = bus.flush &&
                        (rob_age(cdb_rob_tag_q, bus.rob_head) > branch_age);

    assign bus.req_ready   = reset ? (grant_vec | flush_ack) : '0;
    assign bus.cdb_valid   = cdb_valid_q && !out_squash;
    assign bus.cdb_prd     = cdb_prd_q;
    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_rob_tag = cdb_rob_tag_q;
    assign bus.cdb_src     = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed, table-driven bench for cdb_arbiter (STARVE_LIMIT=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int PREG_W  = 7;
    localparam int ROB_W   = 4;
    localparam int XLEN    = 32;

    logic clk;
    logic reset;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .PREG_W(PREG_W), .ROB_W(ROB_W), .XLEN(XLEN)) bus ();

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .PREG_W(PREG_W), .ROB_W(ROB_W), .XLEN(XLEN), .STARVE_LIMIT(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the values expected 1 ns after it is applied.
    // ALU data = 0x1000+prd0, BRU data = 0x2000+prd1, LSU data = d2.
    typedef struct packed {
        logic        rst_n;
        logic [2:0]  valid;
        logic [6:0]  p0, p1, p2;
        logic [3:0]  t0, t1, t2;
        logic [31:0] d2;
        logic        fl;
        logic [3:0]  ft, hd;
        logic [2:0]  rdy;
        logic        chk;
        logic        cv;
        logic [6:0]  cp;
        logic [31:0] cd;
        logic [3:0]  ct;
        logic [1:0]  cs;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic r, input logic [2:0] v,
                                input logic [6:0] p0, p1, p2, input logic [3:0] t0, t1, t2,
                                input logic [31:0] d2, input logic fl, input logic [3:0] ft, hd,
                                input logic [2:0] rdy, input logic chk, input logic cv,
                                input logic [6:0] cp, input logic [31:0] cd,
                                input logic [3:0] ct, input logic [1:0] cs);
        vec_t x;
        x.rst_n = r;  x.valid = v;  x.p0 = p0; x.p1 = p1; x.p2 = p2;
        x.t0 = t0;    x.t1 = t1;    x.t2 = t2; x.d2 = d2; x.fl = fl;
        x.ft = ft;    x.hd = hd;    x.rdy = rdy; x.chk = chk; x.cv = cv;
        x.cp = cp;    x.cd = cd;    x.ct = ct; x.cs = cs;
        return x;
    endfunction

    task automatic apply(input vec_t v);
        reset             = v.rst_n;
        bus.req_valid     = v.valid;
        bus.req_prd       = {v.p2, v.p1, v.p0};
        bus.req_data      = {v.d2, 32'h2000 + 32'(v.p1), 32'h1000 + 32'(v.p0)};
        bus.req_rob_tag   = {v.t2, v.t1, v.t0};
        bus.flush         = v.fl;
        bus.flush_rob_tag = v.ft;
        bus.rob_head      = v.hd;
    endtask

    task automatic check(input vec_t v, input int idx);
        n_checks++;
        if (bus.req_ready !== v.rdy) begin
            n_errors++;
            $display("FAIL vec%0d req_ready got=%b exp=%b", idx, bus.req_ready, v.rdy);
        end
        if (v.chk) begin
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_prd, bus.cdb_data, bus.cdb_rob_tag, bus.cdb_src} !==
                {v.cv, v.cp, v.cd, v.ct, v.cs}) begin
                n_errors++;
                $display("FAIL vec%0d cdb got v=%b prd=%0d data=%h tag=%0d src=%0d exp v=%b prd=%0d data=%h tag=%0d src=%0d",
                         idx, bus.cdb_valid, bus.cdb_prd, bus.cdb_data, bus.cdb_rob_tag, bus.cdb_src,
                         v.cv, v.cp, v.cd, v.ct, v.cs);
            end
        end
    endtask

    initial begin : main
        logic [2:0] exp_rdy;
        logic       got2;

        //            rst v      p0  p1  p2  t0 t1 t2  d2           fl ft  hd | rdy    chk cv cp  cd           ct  cs
        // Reset held with everybody requesting
        vecs[0]  = mk(0, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b000, 0, 0, 0,  32'h0,        0,  0);
        vecs[1]  = mk(0, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b000, 1, 0, 0,  32'h0,        0,  0);
        // Round-robin rotation 0,1,2,0 with one-cycle latency
        vecs[2]  = mk(1, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b001, 1, 0, 0,  32'h0,        0,  0);
        vecs[3]  = mk(1, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b010, 1, 1, 10, 32'h100A,     1,  0);
        vecs[4]  = mk(1, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b100, 1, 1, 11, 32'h200B,     2,  1);
        vecs[5]  = mk(1, 3'b111, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b001, 1, 1, 12, 32'h300C,     3,  2);
        vecs[6]  = mk(1, 3'b000, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b000, 1, 1, 10, 32'h100A,     1,  0);
        vecs[7]  = mk(1, 3'b000, 10, 11, 12, 1, 2, 3,  32'h300C,     0, 0,  0,  3'b000, 1, 0, 10, 32'h100A,     1,  0);
        // Lone LSU request
        vecs[8]  = mk(1, 3'b100, 10, 11, 33, 1, 2, 5,  32'hDEADBEEF, 0, 0,  0,  3'b100, 1, 0, 10, 32'h100A,     1,  0);
        vecs[9]  = mk(1, 3'b000, 10, 11, 33, 1, 2, 5,  32'hDEADBEEF, 0, 0,  0,  3'b000, 1, 1, 33, 32'hDEADBEEF, 5,  2);
        // Flush with wrap: head 14, branch tag 1; BRU tag 2 is younger and acked
        vecs[10] = mk(1, 3'b111, 20, 21, 22, 0, 2, 15, 32'h3016,     1, 1,  14, 3'b011, 1, 0, 33, 32'hDEADBEEF, 5,  2);
        vecs[11] = mk(1, 3'b101, 20, 21, 22, 0, 2, 15, 32'h3016,     0, 1,  14, 3'b100, 1, 1, 20, 32'h1014,     0,  0);
        vecs[12] = mk(1, 3'b000, 20, 21, 22, 0, 2, 15, 32'h3016,     0, 0,  0,  3'b000, 1, 1, 22, 32'h3016,     15, 2);
        // Output squash: registered tag 9, head 6, branch 7 -> killed
        vecs[13] = mk(1, 3'b001, 40, 0,  0,  9, 0, 0,  32'h0,        0, 0,  6,  3'b001, 1, 0, 22, 32'h3016,     15, 2);
        vecs[14] = mk(1, 3'b000, 40, 0,  0,  9, 0, 0,  32'h0,        1, 7,  6,  3'b000, 1, 0, 40, 32'h1028,     9,  0);
        vecs[15] = mk(1, 3'b000, 40, 0,  0,  9, 0, 0,  32'h0,        0, 0,  6,  3'b000, 1, 0, 40, 32'h1028,     9,  0);
        // Registered tag equals the branch -> survives
        vecs[16] = mk(1, 3'b001, 41, 0,  0,  7, 0, 0,  32'h0,        0, 0,  6,  3'b001, 1, 0, 40, 32'h1028,     9,  0);
        vecs[17] = mk(1, 3'b000, 41, 0,  0,  7, 0, 0,  32'h0,        1, 7,  6,  3'b000, 1, 1, 41, 32'h1029,     7,  0);
        // Reset mid-stream, then starvation beats round-robin after a flushed cycle
        vecs[18] = mk(0, 3'b000, 41, 0,  0,  7, 0, 0,  32'h0,        0, 0,  0,  3'b000, 1, 0, 41, 32'h1029,     7,  0);
        vecs[19] = mk(1, 3'b111, 50, 51, 52, 1, 2, 3,  32'h3034,     0, 0,  0,  3'b001, 1, 0, 0,  32'h0,        0,  0);
        vecs[20] = mk(1, 3'b111, 50, 51, 52, 1, 2, 3,  32'h3034,     0, 0,  0,  3'b010, 1, 1, 50, 32'h1032,     1,  0);
        vecs[21] = mk(1, 3'b111, 50, 51, 52, 1, 2, 3,  32'h3034,     1, 2,  0,  3'b101, 1, 1, 51, 32'h2033,     2,  1);
        vecs[22] = mk(1, 3'b111, 50, 51, 52, 1, 2, 3,  32'h3034,     0, 0,  0,  3'b100, 1, 1, 50, 32'h1032,     1,  0);
        vecs[23] = mk(1, 3'b000, 50, 51, 52, 1, 2, 3,  32'h3034,     0, 0,  0,  3'b000, 1, 1, 52, 32'h3034,     3,  2);

        apply(vecs[0]);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check(vecs[i], i);
        end

        // LSU constantly valid against alternating ALU/BRU traffic; pointer starts at 0.
        got2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.req_valid = {1'b1, (c % 2) == 1, (c % 2) == 0};
            bus.flush     = 1'b0;
            #1;
            exp_rdy = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100;
            n_checks++;
            if (bus.req_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL starve_seq cycle%0d req_ready got=%b exp=%b", c, bus.req_ready, exp_rdy);
            end
            if (bus.req_ready[2]) got2 = 1'b1;
        end
        n_checks++;
        if (!got2) begin
            n_errors++;
            $display("FAIL starve_bound lsu_granted got=%b exp=1", got2);
        end

        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It shares the single physical-register-file write port and the wakeup/ROB-complete broadcast among the functional units (ALU, branch unit, LSU). Arbitration is round-robin with a starvation override, and the broadcast is registered. Wrong-path results are squashed on a branch mispredict, both at the request inputs and in the output register.

## Interface
- `NUM_REQ`, default 3: number of requesters. Index 0 = ALU, 1 = BRU, 2 = LSU.
- `PREG_W`, default 7: physical register tag width.
- `ROB_W`, default 4: ROB tag width. ROB depth is 2^ROB_W.
- `XLEN`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive lost cycles before a requester is forced to win.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  result pending, per requester.
- `req_prd`  in  NUM_REQ*PREG_W  destination physical register. Slice i belongs to requester i.
- `req_data`  in  NUM_REQ*XLEN  result value.
- `req_rob_tag`  in  NUM_REQ*ROB_W  ROB entry of the result.
- `req_ready`  out  NUM_REQ  one-hot grant. The requester drops or advances its result on the clock edge where `req_valid[i] && req_ready[i]`.
- `flush`  in  1  mispredict pulse.
- `flush_rob_tag`  in  ROB_W  ROB tag of the mispredicted branch.
- `rob_head`  in  ROB_W  current ROB head. Used for age comparison.
- `cdb_valid`  out  1  broadcast valid. Also acts as the PRF write enable.
- `cdb_prd`  out  PREG_W  broadcast destination register.
- `cdb_data`  out  XLEN  broadcast value.
- `cdb_rob_tag`  out  ROB_W  ROB entry to mark complete.
- `cdb_src`  out  $clog2(NUM_REQ)  index of the requester that won.

## Operation
- **Age:** age(t) = (t − rob_head) mod 2^ROB_W, computed in ROB_W-bit unsigned arithmetic.
- **Younger than the branch:** a tag t is younger when age(t) > age(flush_rob_tag). The branch itself is not younger.
- **Eligibility:** requester i is eligible when `req_valid[i]` is set and it is not (`flush` and younger than the branch).
- **Grant:** each cycle at most one eligible requester is granted. Selection order:
  - Starved requesters first. A requester is starved when its `wait_cnt[i]` ≥ STARVE_LIMIT. Among starved requesters, the lowest index wins.
  - Otherwise round-robin, starting at `rr_ptr` and scanning upward with wrap.
- **Flushed requesters:** a requester that is valid but ineligible because of the flush receives `req_ready[i]` = 1. This consumes and discards its result. Such acks are not counted as the grant.
- **`rr_ptr` update:** on a grant, `rr_ptr` ← (winner + 1) mod NUM_REQ. With no grant it holds.
- **`wait_cnt[i]` update:**
  - Increments, saturating at STARVE_LIMIT, when requester i is eligible but not granted.
  - Clears when it is granted or not valid.
- **Output register:** loads the winner's prd, data, rob_tag and index, and sets `cdb_valid` = 1. With no winner, `cdb_valid` ← 0 and the other output fields hold their values.
- **Output squash:** if `flush` is asserted and the currently registered `cdb_rob_tag` is younger than the branch, `cdb_valid` is forced to 0 combinationally in the same cycle. The next load proceeds normally.
- **State:** none beyond the pointer, counters and output register. There is no FSM. Both the grant logic and `req_ready` are combinational from the inputs.

## Timing
- **Latency:** a grant in cycle N makes the result visible on the `cdb_*` outputs in cycle N+1. The PRF write happens on the edge that ends cycle N+1.
- **Throughput:** one broadcast per cycle.
- **No backpressure:** the CDB always accepts. `req_ready` does not depend on `cdb_*`.
- **Reset** (`reset` = 0 at a posedge):
  - `cdb_valid` = 0; `cdb_prd`, `cdb_data`, `cdb_rob_tag`, `cdb_src` = 0.
  - `rr_ptr` = 0; all `wait_cnt` = 0.
  - `req_ready` = 0 for the whole time reset is asserted.
  - Reset mid-broadcast discards the pending result.
- **`flush` with no requests:** only the output-squash rule applies.
- **Simultaneous flush and grant:** the older winner proceeds. Younger requesters are acked and dropped in the same cycle.
- **ROB tag wrap-around:** handled by the modular age rule. For example, with head=14 and branch tag=1 (age 3), tag 0 (age 2) survives and tag 2 (age 4) is squashed.
- **Several requesters starved at once:** the lowest index wins. The others keep their counters at saturation and win on later cycles.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with all `req_valid` = 1 → `req_ready` = 000 and `cdb_valid` = 0 throughout. The first grant after release goes to index 0, because `rr_ptr` = 0.
- **Round-robin rotation:** all three requesters valid continuously, with `req_prd` = 10/11/12 → `cdb_src` sequence 0,1,2,0,… and `cdb_prd` 10,11,12,10,… Each result appears one cycle after its grant.
- **Single requester:** only the LSU valid with prd=33, data=0xDEADBEEF, tag=5 → `req_ready` = 100 in the same cycle. Next cycle `cdb_valid` = 1, `cdb_prd` = 33, `cdb_data` = 0xDEADBEEF, `cdb_rob_tag` = 5.
- **Starvation override:** set STARVE_LIMIT=2 and drive requester 2 constantly while `rr_ptr` is pinned by alternating 0/1 traffic. Requester 2 is granted no later than its third eligible cycle.
- **Flush at requests, with wrap:** head=14, flush tag=1; ALU tag=0, BRU tag=2, LSU tag=15 → BRU is acked and dropped; the winner comes from ALU or LSU; no broadcast ever carries tag 2.
- **Output squash:** `cdb` holds tag 9 with head=6, then a flush pulse with flush tag=7 → `cdb_valid` reads 0 in the flush cycle. Rerun with `cdb_rob_tag` = 7 → `cdb_valid` stays 1.
